// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM states and the
// per-prescale bit-boundary and consume-edge positions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Edge at which the sampler's registered majority vote is valid.
  localparam int unsigned CONSUME_EDGE_PS8  = 6;
  localparam int unsigned CONSUME_EDGE_PS16 = 10;
  localparam int unsigned CONSUME_EDGE_PS32 = 17;

  function automatic int unsigned consume_edge(input int unsigned prescale);
    case (prescale)
      16:      return CONSUME_EDGE_PS16;
      32:      return CONSUME_EDGE_PS32;
      default: return CONSUME_EDGE_PS8;
    endcase
  endfunction

  function automatic int unsigned prescale_wrap(input int unsigned prescale);
    case (prescale)
      16:      return 15;
      32:      return 31;
      default: return 7;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter wrapping at the bit boundary, plus the data-bit
// counter with explicit clear and increment controls.
module uart_rx_edge_bit_counter #(
  parameter int EDGE_W = 5,
  parameter int BIT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_edge_clear,
  input  logic [EDGE_W-1:0] i_wrap,
  input  logic              i_bit_clear,
  input  logic              i_bit_inc,
  output logic [EDGE_W-1:0] o_edge_count,
  output logic              o_boundary,
  output logic [BIT_W-1:0]  o_bit_count
);

  logic [EDGE_W-1:0] edge_reg;
  logic [BIT_W-1:0]  bit_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      edge_reg <= '0;
    end else if (i_edge_clear || (edge_reg == i_wrap)) begin
      edge_reg <= '0;
    end else begin
      edge_reg <= edge_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_reg <= '0;
    end else if (i_bit_clear) begin
      bit_reg <= '0;
    end else if (i_bit_inc) begin
      bit_reg <= bit_reg + 1'b1;
    end
  end

  assign o_edge_count = edge_reg;
  assign o_boundary   = (edge_reg == i_wrap);
  assign o_bit_count  = bit_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, frame sequencing, LSB-first
// deserialization and parity/stop status reporting.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_MAX = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int PS_W         = $clog2(PRESCALE_MAX) + 1,
  parameter int EDGE_W       = $clog2(PRESCALE_MAX)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic [PS_W-1:0]       i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_sampled_bit,
  output logic                  o_sampling_enable,
  output logic [EDGE_W-1:0]     o_edge_count,
  output logic [BYTE_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stop_err,
  output logic                  o_busy
);

  localparam int BIT_W = $clog2(BYTE_WIDTH + 1);

  rx_state_e state_reg, state_next;

  logic [EDGE_W-1:0]     wrap_reg, consume_reg;
  logic [EDGE_W-1:0]     wrap_sel, consume_sel;
  logic [EDGE_W-1:0]     edge_count;
  logic [BIT_W-1:0]      bit_count;
  logic                  boundary, at_consume;
  logic                  par_en_reg, par_typ_reg, par_err_reg;
  logic [BYTE_WIDTH-1:0] shift_reg, data_reg;
  logic                  valid_reg, par_pulse_reg, stop_pulse_reg, busy_reg;

  logic edge_clear, bit_clear, bit_inc, shift_en, par_capture, frame_done;
  logic start_detect;

  always_comb begin
    wrap_sel    = EDGE_W'(prescale_wrap(32'(i_prescale)));
    consume_sel = EDGE_W'(consume_edge(32'(i_prescale)));
  end

  assign at_consume   = (edge_count == consume_reg);
  assign start_detect = (state_reg == IDLE) && !i_rx_in;

  always_comb begin
    state_next  = state_reg;
    bit_clear   = 1'b0;
    bit_inc     = 1'b0;
    shift_en    = 1'b0;
    par_capture = 1'b0;
    frame_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        bit_clear = 1'b1;
        if (!i_rx_in) state_next = START;
      end
      START: begin
        // A high vote mid start bit means the falling edge was noise.
        if (at_consume && i_sampled_bit) begin
          state_next = IDLE;
        end else if (boundary) begin
          state_next = DATA;
          bit_clear  = 1'b1;
        end
      end
      DATA: begin
        shift_en = at_consume;
        if (boundary) begin
          bit_inc = 1'b1;
          if (bit_count == BIT_W'(BYTE_WIDTH - 1)) begin
            state_next = par_en_reg ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        par_capture = at_consume;
        if (boundary) state_next = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (at_consume) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign edge_clear = (state_reg == IDLE) || (state_next == IDLE);

  uart_rx_edge_bit_counter #(
    .EDGE_W (EDGE_W),
    .BIT_W  (BIT_W)
  ) u_edge_bit_counter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_edge_clear (edge_clear),
    .i_wrap       (wrap_reg),
    .i_bit_clear  (bit_clear),
    .i_bit_inc    (bit_inc),
    .o_edge_count (edge_count),
    .o_boundary   (boundary),
    .o_bit_count  (bit_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      wrap_reg       <= '0;
      consume_reg    <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      par_err_reg    <= 1'b0;
      shift_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      par_pulse_reg  <= 1'b0;
      stop_pulse_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      if (start_detect) begin
        wrap_reg    <= wrap_sel;
        consume_reg <= consume_sel;
        par_en_reg  <= i_par_en;
        par_typ_reg <= i_par_typ;
        par_err_reg <= 1'b0;
      end
      if (shift_en) shift_reg <= {i_sampled_bit, shift_reg[BYTE_WIDTH-1:1]};
      if (par_capture) par_err_reg <= i_sampled_bit ^ (^shift_reg) ^ par_typ_reg;
      if (frame_done) data_reg <= shift_reg;
      valid_reg      <= frame_done && i_sampled_bit && !par_err_reg;
      par_pulse_reg  <= frame_done && par_err_reg;
      stop_pulse_reg <= frame_done && !i_sampled_bit;
    end
  end

  assign o_sampling_enable = busy_reg;
  assign o_busy            = busy_reg;
  assign o_edge_count      = edge_count;
  assign o_data            = data_reg;
  assign o_data_valid      = valid_reg;
  assign o_par_err         = par_pulse_reg;
  assign o_stop_err        = stop_pulse_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of whole frames plus hand-written
// glitch, back-to-back, mid-frame config change and mid-frame reset sequences.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       sampled;
  logic       sen;
  logic [4:0] ecount;
  logic [7:0] data;
  logic       dv, pe, se, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       v, p, s;
  } pulse_t;
  pulse_t pq[$];

  typedef struct {
    logic [5:0] ps_cfg;
    int         ps_line;
    logic       pen, ptyp;
    logic [7:0] d;
    logic       pbit, sbit;
    logic [7:0] exp_d;
    logic       ev, ep, es;
    int         lat;
  } vec_t;
  vec_t vecs[7];

  uart_rx_ctrl dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rx_in           (rx),
    .i_prescale        (prescale),
    .i_par_en          (par_en),
    .i_par_typ         (par_typ),
    .i_sampled_bit     (sampled),
    .o_sampling_enable (sen),
    .o_edge_count      (ecount),
    .o_data            (data),
    .o_data_valid      (dv),
    .o_par_err         (pe),
    .o_stop_err        (se),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv || pe || se) begin
      pq.push_back('{cyc, data, dv, pe, se});
      $display("pulse cyc=%0d data=%02h valid=%0b par_err=%0b stop_err=%0b", cyc, data, dv, pe, se);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sampler model: the voted bit follows the line, which is stable at the consume edge.
  task automatic set_line(input logic b);
    rx      = b;
    sampled = b;
  endtask

  task automatic drive_bit(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      set_line(b);
    end
  endtask

  task automatic send_frame(input int ps, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit, output int t_low);
    @(posedge clk);
    #1;
    set_line(1'b0);
    t_low = cyc;
    drive_bit(1'b0, ps - 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
    if (pen) drive_bit(pbit, ps);
    drive_bit(sbit, ps);
  endtask

  task automatic wait_cycle(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int t_low, t1, t2;

    rst = 1'b1;
    set_line(1'b1);
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;

    //           ps_cfg ps  pen ptyp d      pbit sbit exp_d  ev    ep    es    lat
    vecs[0] = '{6'd8,   8,  0,  0,   8'hA5, 0,   1,   8'hA5, 1'b1, 1'b0, 1'b0, 79};
    vecs[1] = '{6'd16,  16, 1,  0,   8'h3C, 0,   1,   8'h3C, 1'b1, 1'b0, 1'b0, 171};
    vecs[2] = '{6'd16,  16, 1,  0,   8'h3C, 1,   1,   8'h3C, 1'b0, 1'b1, 1'b0, 171};
    vecs[3] = '{6'd32,  32, 1,  1,   8'h01, 0,   0,   8'h01, 1'b0, 1'b0, 1'b1, 338};
    vecs[4] = '{6'd12,  8,  0,  0,   8'h96, 0,   1,   8'h96, 1'b1, 1'b0, 1'b0, 79};
    vecs[5] = '{6'd32,  32, 0,  0,   8'hC3, 0,   1,   8'hC3, 1'b1, 1'b0, 1'b0, 306};
    vecs[6] = '{6'd8,   8,  1,  1,   8'h0F, 0,   0,   8'h0F, 1'b0, 1'b1, 1'b1, 87};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sen", 32'(sen), 32'd0);
    check("reset_edge", 32'(ecount), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_pulses", 32'({dv, pe, se}), 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 5);

    for (int v = 0; v < 7; v++) begin
      prescale = vecs[v].ps_cfg;
      par_en   = vecs[v].pen;
      par_typ  = vecs[v].ptyp;
      pq.delete();
      send_frame(vecs[v].ps_line, vecs[v].d, vecs[v].pen, vecs[v].pbit, vecs[v].sbit, t_low);
      drive_bit(1'b1, 3 * vecs[v].ps_line + 10);
      $display("vec %0d data=%02h t_low=%0d pulses=%0d", v, vecs[v].d, t_low, pq.size());
      check($sformatf("v%0d_pulse_count", v), 32'(pq.size()), 32'd1);
      if (pq.size() > 0) begin
        check($sformatf("v%0d_pulse_cycle", v), 32'(pq[0].cyc), 32'(t_low + 1 + vecs[v].lat));
        check($sformatf("v%0d_data", v), 32'(pq[0].data), 32'(vecs[v].exp_d));
        check($sformatf("v%0d_valid", v), 32'(pq[0].v), 32'(vecs[v].ev));
        check($sformatf("v%0d_par_err", v), 32'(pq[0].p), 32'(vecs[v].ep));
        check($sformatf("v%0d_stop_err", v), 32'(pq[0].s), 32'(vecs[v].es));
      end
      check($sformatf("v%0d_data_hold", v), 32'(data), 32'(vecs[v].exp_d));
      check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
    end

    // Glitch: three low cycles, then a good frame.
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    pq.delete();
    @(posedge clk);
    #1;
    set_line(1'b0);
    t_low = cyc;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 1);
    wait_cycle(t_low + 7);
    check("glitch_busy_at_c", 32'(busy), 32'd1);
    check("glitch_edge_at_c", 32'(ecount), 32'd6);
    wait_cycle(t_low + 8);
    check("glitch_back_idle", 32'(busy), 32'd0);
    check("glitch_sen_off", 32'(sen), 32'd0);
    drive_bit(1'b1, 10);
    check("glitch_no_pulse", 32'(pq.size()), 32'd0);
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1, t_low);
    drive_bit(1'b1, 30);
    $display("glitch then 0x55 t_low=%0d pulses=%0d", t_low, pq.size());
    check("after_glitch_count", 32'(pq.size()), 32'd1);
    if (pq.size() > 0) begin
      check("after_glitch_cycle", 32'(pq[0].cyc), 32'(t_low + 80));
      check("after_glitch_data", 32'(pq[0].data), 32'h55);
      check("after_glitch_valid", 32'(pq[0].v), 32'd1);
    end

    // Back-to-back frames, no idle gap.
    pq.delete();
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b1, t1);
    send_frame(8, 8'h00, 1'b0, 1'b0, 1'b1, t2);
    drive_bit(1'b1, 30);
    $display("back-to-back t1=%0d t2=%0d pulses=%0d", t1, t2, pq.size());
    check("b2b_count", 32'(pq.size()), 32'd2);
    if (pq.size() > 1) begin
      check("b2b_cycle0", 32'(pq[0].cyc), 32'(t1 + 80));
      check("b2b_cycle1", 32'(pq[1].cyc), 32'(t2 + 80));
      check("b2b_spacing", 32'(pq[1].cyc - pq[0].cyc), 32'd80);
      check("b2b_data0", 32'(pq[0].data), 32'hFF);
      check("b2b_data1", 32'(pq[1].data), 32'h00);
      check("b2b_valid", 32'({pq[0].v, pq[1].v}), 32'd3);
    end

    // Config change mid-frame is ignored.
    prescale = 6'd16;
    par_en   = 1'b0;
    pq.delete();
    fork
      send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b1, t_low);
      begin
        repeat (40) @(posedge clk);
        #1;
        prescale = 6'd8;
        par_en   = 1'b1;
      end
    join
    drive_bit(1'b1, 60);
    $display("cfg change t_low=%0d pulses=%0d", t_low, pq.size());
    check("cfgchg_count", 32'(pq.size()), 32'd1);
    if (pq.size() > 0) begin
      check("cfgchg_cycle", 32'(pq[0].cyc), 32'(t_low + 1 + 155));
      check("cfgchg_data", 32'(pq[0].data), 32'h5A);
      check("cfgchg_valid", 32'(pq[0].v), 32'd1);
      check("cfgchg_par_err", 32'(pq[0].p), 32'd0);
    end

    // Reset during data bit 4.
    prescale = 6'd8;
    par_en   = 1'b0;
    pq.delete();
    @(posedge clk);
    #1;
    set_line(1'b0);
    drive_bit(1'b0, 7);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hA5 >> i), 8);
    drive_bit(1'b0, 4);
    check("midrst_busy_before", 32'(busy), 32'd1);
    check("midrst_edge_before", 32'(ecount), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sen", 32'(sen), 32'd0);
    check("midrst_edge", 32'(ecount), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_pulses", 32'({dv, pe, se}), 32'd0);
    set_line(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(1'b1, 100);
    $display("mid-frame reset pulses=%0d", pq.size());
    check("midrst_no_pulse", 32'(pq.size()), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
